// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq: fetches a 16-bit instruction as two byte reads at PC, PC+1 via the address register file
module instr_fetch_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        ir_ready,
  input  logic        mem_wait,
  input  logic [7:0]  mem_data,
  output logic [1:0]  arf_outb_sel,
  output logic [1:0]  arf_funsel,
  output logic [3:0]  arf_rsel,
  output logic        mem_rd,
  output logic [15:0] ir,
  output logic        ir_valid,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, ADDR_LO, READ_LO, ADDR_HI, READ_HI, DONE} state_t;
  state_t state, nxt;
  logic inc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ir    <= '0;
    end else begin
      state <= nxt;
      if (state == READ_LO && !mem_wait) ir[7:0]  <= mem_data;
      if (state == READ_HI && !mem_wait) ir[15:8] <= mem_data;
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? ADDR_LO : IDLE;
      ADDR_LO: nxt = READ_LO;
      READ_LO: nxt = mem_wait ? READ_LO : ADDR_HI;
      ADDR_HI: nxt = READ_HI;
      READ_HI: nxt = mem_wait ? READ_HI : DONE;
      DONE:    nxt = ir_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
    mem_rd       = state == READ_LO || state == READ_HI;
    inc          = mem_rd && !mem_wait;
    arf_rsel     = inc ? 4'b1000 : 4'b0000;
    arf_funsel   = inc ? 2'b10 : 2'b01;
    arf_outb_sel = 2'b11;
    busy         = state != IDLE;
    ir_valid     = state == DONE;
  end
endmodule

// File: tb/tb_instr_fetch_seq.sv
// tb_instr_fetch_seq: directed vectors against a small PC/registered-B-output/memory model
module tb_instr_fetch_seq;
  logic clk = 0, rst = 1, start = 0, ir_ready = 0, mem_wait = 0;
  logic [7:0] mem_data;
  logic [1:0] arf_outb_sel, arf_funsel;
  logic [3:0] arf_rsel;
  logic mem_rd, ir_valid, busy;
  logic [15:0] ir;
  logic [7:0] mem [256];
  logic [7:0] pc = 0, outb = 0, pc_init = 0;
  logic pc_load = 0;
  int errors = 0, checks = 0;

  instr_fetch_seq dut (.clk(clk), .rst(rst), .start(start), .ir_ready(ir_ready), .mem_wait(mem_wait),
    .mem_data(mem_data), .arf_outb_sel(arf_outb_sel), .arf_funsel(arf_funsel), .arf_rsel(arf_rsel),
    .mem_rd(mem_rd), .ir(ir), .ir_valid(ir_valid), .busy(busy));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pc_load) pc <= pc_init;
    else if (arf_rsel[3] && arf_funsel == 2'b10) pc <= pc + 8'd1;
    outb <= arf_outb_sel == 2'b11 ? pc : 8'h00;
  end
  assign mem_data = mem[outb];

  typedef struct {
    logic [7:0] pc, lo, hi;
    int stall_lo, stall_hi, delay;
    logic [15:0] exp_ir;
    logic [7:0] exp_pc;
    int exp_lat;
  } vec_t;
  vec_t vecs [5];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load(input logic [7:0] p, input logic [7:0] lo, input logic [7:0] hi);
    logic [7:0] a;
    a = p + 8'd1;
    mem[p] = lo;
    mem[a] = hi;
    pc_init = p;
    pc_load = 1;
    tick;
    pc_load = 0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int edges, wl, wh, rs, rd;
    logic lo_done, stall_bad, hold_bad;
    logic [15:0] held;
    edges = 1; wl = 0; wh = 0; rs = 0; rd = 0;
    lo_done = 0; stall_bad = 0; hold_bad = 0;
    load(v.pc, v.lo, v.hi);
    ir_ready = 0;
    start = 1;
    tick;
    start = 0;
    while (!ir_valid && edges < 40) begin
      mem_wait = 0;
      if (mem_rd) begin
        if (!lo_done && wl < v.stall_lo) begin mem_wait = 1; wl++; end
        else if (lo_done && wh < v.stall_hi) begin mem_wait = 1; wh++; end
      end
      #1;
      if (mem_rd) rd++;
      if (arf_rsel == 4'b1000) rs++;
      if (mem_wait && arf_rsel != 4'b0000) stall_bad = 1;
      if (mem_rd && !mem_wait) lo_done = 1;
      tick;
      edges++;
    end
    mem_wait = 0;
    chk({nm, " latency"}, edges, v.exp_lat);
    chk({nm, " ir"}, ir, v.exp_ir);
    chk({nm, " rsel cycles"}, rs, 2);
    chk({nm, " mem_rd cycles"}, rd, 2 + v.stall_lo + v.stall_hi);
    chk({nm, " rsel during stall"}, stall_bad, 0);
    held = ir;
    for (int dn = 0; dn < v.delay; dn++) begin
      start = (dn % 2 == 0);
      tick;
      if (!ir_valid || !busy || ir !== held) hold_bad = 1;
    end
    start = 0;
    chk({nm, " done hold"}, hold_bad, 0);
    chk({nm, " pc end"}, pc, v.exp_pc);
    ir_ready = 1;
    tick;
    ir_ready = 0;
    chk({nm, " exit to idle"}, {busy, ir_valid}, 2'b00);
    tick;
    chk({nm, " no queued start"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] got [3];
    int at [3];
    int nv;
    vec_t v;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    vecs[0] = '{8'h10, 8'h34, 8'h12, 0, 0, 0, 16'h1234, 8'h12, 5};
    vecs[1] = '{8'h10, 8'h34, 8'h12, 3, 0, 0, 16'h1234, 8'h12, 8};
    vecs[2] = '{8'h10, 8'h34, 8'h12, 0, 0, 4, 16'h1234, 8'h12, 5};
    vecs[3] = '{8'hFF, 8'hCD, 8'hAB, 0, 0, 0, 16'hABCD, 8'h01, 5};
    vecs[4] = '{8'h40, 8'h5A, 8'hA5, 1, 2, 1, 16'hA55A, 8'h42, 8};
    #3;
    chk("reset outputs", {ir, ir_valid, busy, mem_rd, arf_rsel, arf_funsel, arf_outb_sel},
        {16'h0000, 3'b000, 4'b0000, 2'b01, 2'b11});
    tick;
    tick;
    rst = 0;
    tick;
    chk("idle after reset", busy, 0);
    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    load(8'h20, 8'h77, 8'h66);
    start = 1;
    tick;
    start = 0;
    tick;
    tick;
    tick;
    chk("mid reset in read_hi", {mem_rd, arf_rsel}, {1'b1, 4'b1000});
    #2 rst = 1;
    #1;
    chk("mid reset outputs", {ir, ir_valid, busy, mem_rd, arf_rsel, arf_funsel, arf_outb_sel},
        {16'h0000, 3'b000, 4'b0000, 2'b01, 2'b11});
    tick;
    rst = 0;
    tick;
    tick;
    chk("mid reset pc once", pc, 8'h21);
    chk("mid reset needs start", busy, 0);
    v = '{8'h21, 8'h9C, 8'h3E, 0, 0, 0, 16'h3E9C, 8'h23, 5};
    run_vec(v, "after reset");

    load(8'h30, 8'h01, 8'h02);
    mem[8'h32] = 8'h03; mem[8'h33] = 8'h04; mem[8'h34] = 8'h05; mem[8'h35] = 8'h06;
    start = 1;
    ir_ready = 1;
    nv = 0;
    for (int e = 1; e <= 18; e++) begin
      tick;
      if (ir_valid && nv < 3) begin
        got[nv] = ir;
        at[nv] = e;
        nv++;
      end
    end
    start = 0;
    ir_ready = 0;
    chk("b2b count", nv, 3);
    chk("b2b ir0", got[0], 16'h0201);
    chk("b2b ir1", got[1], 16'h0403);
    chk("b2b ir2", got[2], 16'h0605);
    chk("b2b edge0", at[0], 5);
    chk("b2b edge1", at[1], 11);
    chk("b2b edge2", at[2], 17);
    chk("b2b pc end", pc, 8'h36);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
